// File: rtl/vga_stream_gen_if.sv
// vga_stream_gen_if: processed-pixel stream (frame/line valid, pixel strobe, RGB565, coordinates).
interface vga_stream_gen_if;
  logic        post_vs;
  logic        post_hs;
  logic        post_clken;
  logic [15:0] post_imgdata;
  logic [11:0] px;
  logic [11:0] py;

  modport master (output post_vs, post_hs, post_clken, post_imgdata, px, py);
  modport slave  (input  post_vs, post_hs, post_clken, post_imgdata, px, py);
endinterface

// File: rtl/vga_stream_gen.sv
// vga_stream_gen: counter-timed RGB565 pixel-stream source pulling from a 1-cycle-latency FIFO.
// Optional macro PATTERN_GEN_EN adds pattern_sel and an internal 8-bar colour pattern.
module vga_stream_gen #(
  parameter int          H_ACTIVE        = 640,
  parameter int          H_BLANK         = 160,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_BLANK         = 45,
  parameter int          CLK_DIV         = 1,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef PATTERN_GEN_EN
  input  logic             pattern_sel,
`endif
  input  logic             fifo_empty,
  input  logic [15:0]      fifo_rd_data,
  output logic             fifo_rd_en,
  vga_stream_gen_if.master stream,
  output logic             frame_done,
  output logic [15:0]      underflow_cnt
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [11:0]   H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0]   V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0]   H_LAST   = 12'(H_ACTIVE + H_BLANK - 1);
  localparam logic [11:0]   V_LAST   = 12'(V_ACTIVE + V_BLANK - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] div;
  logic [11:0]   h, v;
  logic          run, tick, slot_end, line_end, frame_end, act, need, miss, start;
  logic          pat;
  logic [15:0]   pat_pix;

  // Pixel slot starts at div==0 (tick) and h/v step at the slot's last clk,
  // so every coordinate, including the first, spans exactly CLK_DIV clks.
  always_comb begin
    run       = (state == RUN);
    tick      = (div == '0);
    slot_end  = (div == DIV_LAST);
    line_end  = slot_end && (h == H_LAST);
    frame_end = line_end && (v == V_LAST);
    act       = (h < H_ACT) && (v < V_ACT);
    need      = run && act && tick;
    start     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (en) begin
        state_nxt = RUN;
        start     = 1'b1;
      end
      RUN: if (frame_end && !en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en = need && !fifo_empty && !pat;
  assign miss       = need && fifo_empty && !pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div   <= '0;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_nxt;
      if (start || !run) begin
        div <= '0;
        h   <= '0;
        v   <= '0;
      end else begin
        div <= slot_end ? '0 : div + 1'b1;
        if (slot_end) begin
          h <= (h == H_LAST) ? '0 : h + 12'd1;
          if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 underflow_cnt <= '0;
    else if (start)                             underflow_cnt <= '0;
    else if (miss && (underflow_cnt != '1))     underflow_cnt <= underflow_cnt + 16'd1;
  end

`ifdef PATTERN_GEN_EN
  localparam logic [11:0] SEG_LAST = 12'(H_ACTIVE / 8 - 1);
  logic [11:0] seg;
  logic [2:0]  bar;
  logic        pat_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_mode <= 1'b0;
      seg      <= '0;
      bar      <= '0;
    end else begin
      if (start || (run && frame_end)) pat_mode <= pattern_sel;
      if (start || !run || line_end) begin
        seg <= '0;
        bar <= '0;
      end else if (slot_end && act) begin
        if (seg == SEG_LAST) begin
          seg <= '0;
          bar <= bar + 3'd1;
        end else begin
          seg <= seg + 12'd1;
        end
      end
    end
  end

  always_comb begin
    pat_pix = '0;
    case (bar)
      3'd0: pat_pix = 16'hFFFF;
      3'd1: pat_pix = 16'hFFE0;
      3'd2: pat_pix = 16'h07FF;
      3'd3: pat_pix = 16'h07E0;
      3'd4: pat_pix = 16'hF81F;
      3'd5: pat_pix = 16'hF800;
      3'd6: pat_pix = 16'h001F;
      default: pat_pix = 16'h0000;
    endcase
  end

  assign pat = pat_mode;
`else
  assign pat     = 1'b0;
  assign pat_pix = '0;
`endif

  logic        clken_q, miss_q, last_q, pat_q;
  logic [15:0] hold_q, pat_pix_q, pix;

  // FIFO data arrives in the stage-1 cycle, so the pixel is muxed live and latched for hold.
  assign pix                 = pat_q ? pat_pix_q : (miss_q ? UNDERFLOW_COLOR : fifo_rd_data);
  assign stream.post_clken   = clken_q;
  assign stream.post_imgdata = clken_q ? pix : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clken_q        <= 1'b0;
      miss_q         <= 1'b0;
      last_q         <= 1'b0;
      pat_q          <= 1'b0;
      pat_pix_q      <= '0;
      hold_q         <= '0;
      frame_done     <= 1'b0;
      stream.post_hs <= 1'b0;
      stream.post_vs <= 1'b0;
      stream.px      <= '0;
      stream.py      <= '0;
    end else begin
      clken_q        <= need;
      miss_q         <= miss;
      pat_q          <= pat;
      pat_pix_q      <= pat_pix;
      last_q         <= need && (h == H_ACT - 12'd1) && (v == V_ACT - 12'd1);
      frame_done     <= last_q;
      stream.post_hs <= run && act;
      stream.post_vs <= run && (v < V_ACT);
      stream.px      <= h;
      stream.py      <= v;
      if (!run)         hold_q <= '0;
      else if (clken_q) hold_q <= pix;
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Randomized self-checking bench for vga_stream_gen against a raster-arithmetic reference model.
`timescale 1ns/1ps
module tb_vga_stream_gen;
  localparam int HA = 4, HB = 2, VA = 3, VB = 1;
  localparam int HT = HA + HB, VT = VA + VB;
  localparam logic [15:0] UFC = 16'hF800;
  localparam int NCAP = 256;

  typedef struct packed {
    logic rd, vs, hs, ck, fd;
    logic [15:0] dat;
    logic [11:0] px, py;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic fifo_empty;
  logic [15:0] fifo_rd_data = '0;
  logic rd_a, rd_b, rd_c, fd_a, fd_b;
  logic [15:0] uf_a, uf_b;
  vga_stream_gen_if if_a ();
  vga_stream_gen_if if_b ();

  int checks = 0, errors = 0;
  int sel = 0;
  int viol = 0;
  obs_t cur;
  logic [15:0] uf_cur;
  obs_t cap [NCAP];
  obs_t expv [NCAP];
  logic [15:0] words [64];

  always #5 clk = ~clk;

  // FIFO model: standard read, data valid one clk after the read strobe
  logic [15:0] mem [256];
  int wr_cnt = 0, rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_cnt);
  always @(posedge clk)
    if ((rd_a || rd_b || rd_c) && (rd_ptr != wr_cnt)) begin
      fifo_rd_data <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end

`ifdef PATTERN_GEN_EN
  logic pat_off = 1'b0, pat_sel_c = 1'b0, en_c = 1'b0, fd_c;
  logic [15:0] uf_c;
  vga_stream_gen_if if_c ();
  vga_stream_gen #(.H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(2), .V_BLANK(1), .CLK_DIV(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .pattern_sel(pat_sel_c), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_c), .stream(if_c), .frame_done(fd_c),
    .underflow_cnt(uf_c));
`else
  assign rd_c = 1'b0;
`endif

  vga_stream_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CLK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a),
`ifdef PATTERN_GEN_EN
    .pattern_sel(pat_off),
`endif
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_a), .stream(if_a),
    .frame_done(fd_a), .underflow_cnt(uf_a));

  vga_stream_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CLK_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
`ifdef PATTERN_GEN_EN
    .pattern_sel(pat_off),
`endif
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_b), .stream(if_b),
    .frame_done(fd_b), .underflow_cnt(uf_b));

  always_comb begin
    if (sel == 1) begin
      cur = {rd_b, if_b.post_vs, if_b.post_hs, if_b.post_clken, fd_b, if_b.post_imgdata, if_b.px, if_b.py};
      uf_cur = uf_b;
    end else begin
      cur = {rd_a, if_a.post_vs, if_a.post_hs, if_a.post_clken, fd_a, if_a.post_imgdata, if_a.px, if_a.py};
      uf_cur = uf_a;
    end
  end

  // ---------------- reference model (raster arithmetic) ----------------
  function automatic bit need_at(input int t, input int div, input int run_len);
    int s, h, v;
    if (t < 0 || t >= run_len) return 1'b0;
    s = t / div; h = s % HT; v = (s / HT) % VT;
    return (t % div == 0) && (h < HA) && (v < VA);
  endfunction

  function automatic int pix_no(input int t, input int div);
    int s;
    s = t / div;
    return (s / (HT * VT)) * (HA * VA) + ((s / HT) % VT) * HA + (s % HT);
  endfunction

  // en is looked at only on the last clk of each frame
  function automatic int run_len_of(input int drop_at, input int div);
    int fl;
    fl = HT * VT * div;
    return ((drop_at + 2 + fl - 1) / fl) * fl;
  endfunction

  task automatic build_expect(input int div, input int nwords, input int run_len, input int ncap,
                              output int misses);
    logic [15:0] held;
    held = '0;
    misses = 0;
    for (int k = 0; k < ncap; k++) begin
      obs_t e;
      e = '0;
      if (need_at(k, div, run_len)) e.rd = (pix_no(k, div) < nwords);
      if (k >= 1 && k - 1 < run_len) begin
        int t, s, h, v;
        t = k - 1; s = t / div; h = s % HT; v = (s / HT) % VT;
        e.hs = (h < HA) && (v < VA);
        e.vs = (v < VA);
        e.px = 12'(h);
        e.py = 12'(v);
        e.ck = need_at(t, div, run_len);
        if (e.ck) held = (pix_no(t, div) < nwords) ? words[pix_no(t, div)] : UFC;
      end
      if (k >= run_len + 1) held = '0;
      e.dat = held;
      e.fd = need_at(k - 2, div, run_len) && (pix_no(k - 2, div) % (HA * VA) == HA * VA - 1);
      expv[k] = e;
    end
    for (int t = 0; t < run_len; t++)
      if (need_at(t, div, run_len) && pix_no(t, div) >= nwords) misses++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load_fifo(input int n);
    wr_cnt = rd_ptr;
    for (int i = 0; i < n; i++) begin
      words[i] = 16'($urandom_range(1, 16'hF7FF));
      mem[(rd_ptr + i) % 256] = words[i];
    end
    wr_cnt = rd_ptr + n;
  endtask

  task automatic run_capture(input int ncap, input int drop_at);
    if (sel == 1) en_b = 1'b1; else en_a = 1'b1;
    for (int k = 0; k < ncap; k++) begin
      @(negedge clk);
      cap[k] = cur;
      if ((rd_a || rd_b || rd_c) && fifo_empty) viol++;
      if (k == drop_at) begin
        en_a = 1'b0;
        en_b = 1'b0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i;
      #1;
      checks++;
      if (cur !== obs_t'(0)) begin
        errors++; $display("FAIL reset_outputs inst=%0d got=%h exp=0", i, cur);
      end
      checks++;
      if (uf_cur !== 16'h0) begin
        errors++; $display("FAIL reset_underflow inst=%0d got=%h exp=0", i, uf_cur);
      end
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fifo_frame;
    int drop, rl, miss, nck, nvs, nfd;
    sel = 0;
    load_fifo(12);
    drop = $urandom_range(0, 20);
    rl = run_len_of(drop, 1);
    build_expect(1, 12, rl, 30, miss);
    run_capture(30, drop);
    nck = 0; nvs = 0; nfd = 0;
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (cap[k] !== expv[k]) begin
        errors++; $display("FAIL fifo_frame cyc=%0d got=%h exp=%h", k, cap[k], expv[k]);
      end
      nck += int'(cap[k].ck); nvs += int'(cap[k].vs); nfd += int'(cap[k].fd);
    end
    checks++;
    if (nck !== 12) begin errors++; $display("FAIL fifo_frame_clken_count got=%0d exp=12", nck); end
    checks++;
    if (nvs !== 18) begin errors++; $display("FAIL fifo_frame_vs_clks got=%0d exp=18", nvs); end
    checks++;
    if (nfd !== 1) begin errors++; $display("FAIL fifo_frame_done_count got=%0d exp=1", nfd); end
    checks++;
    if (uf_cur !== 16'(miss)) begin errors++; $display("FAIL fifo_frame_underflow got=%0d exp=%0d", uf_cur, miss); end
  endtask

  task automatic test_underflow;
    int drop, rl, miss;
    sel = 0;
    viol = 0;
    load_fifo(10);
    drop = $urandom_range(0, 20);
    rl = run_len_of(drop, 1);
    build_expect(1, 10, rl, 30, miss);
    run_capture(30, drop);
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (cap[k] !== expv[k]) begin
        errors++; $display("FAIL underflow cyc=%0d got=%h exp=%h", k, cap[k], expv[k]);
      end
    end
    checks++;
    if (uf_cur !== 16'd2) begin errors++; $display("FAIL underflow_cnt got=%0d exp=2", uf_cur); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL rd_while_empty got=%0d exp=0", viol); end
  endtask

  task automatic test_clk_div;
    int drop, rl, miss, hs1;
    sel = 1;
    load_fifo(12);
    drop = $urandom_range(0, 69);
    rl = run_len_of(drop, 3);
    build_expect(3, 12, rl, 80, miss);
    run_capture(80, drop);
    hs1 = 0;
    for (int k = 0; k < 80; k++) begin
      checks++;
      if (cap[k] !== expv[k]) begin
        errors++; $display("FAIL clk_div cyc=%0d got=%h exp=%h", k, cap[k], expv[k]);
      end
      if (k >= 1 && k <= 18) hs1 += int'(cap[k].hs);
    end
    checks++;
    if (hs1 !== 12) begin errors++; $display("FAIL clk_div_hs_line got=%0d exp=12", hs1); end
    checks++;
    if (uf_cur !== 16'(miss)) begin errors++; $display("FAIL clk_div_underflow got=%0d exp=%0d", uf_cur, miss); end
    sel = 0;
  endtask

  task automatic test_en_drop;
    int drop, rl, miss;
    sel = 0;
    viol = 0;
    load_fifo(24);
    drop = $urandom_range(24, 45);
    rl = run_len_of(drop, 1);
    build_expect(1, 24, rl, 60, miss);
    run_capture(60, drop);
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (cap[k] !== expv[k]) begin
        errors++; $display("FAIL en_drop cyc=%0d got=%h exp=%h", k, cap[k], expv[k]);
      end
    end
    checks++;
    if (cap[59] !== obs_t'(0)) begin errors++; $display("FAIL en_drop_idle got=%h exp=0", cap[59]); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL en_drop_rd_while_empty got=%0d exp=0", viol); end
  endtask

  task automatic test_async_reset;
    int k0, drop, rl, miss;
    sel = 0;
    load_fifo(12);
    k0 = $urandom_range(6, 8);
    en_a = 1'b1;
    repeat (k0 + 1) @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (cur.hs !== 1'b1) begin errors++; $display("FAIL areset_pre_hs got=%b exp=1", cur.hs); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur !== obs_t'(0)) begin errors++; $display("FAIL areset_outputs got=%h exp=0", cur); end
    checks++;
    if (uf_cur !== 16'h0) begin errors++; $display("FAIL areset_underflow got=%h exp=0", uf_cur); end
    @(negedge clk);
    load_fifo(12);
    rst_n = 1'b1;
    drop = $urandom_range(0, 20);
    rl = run_len_of(drop, 1);
    build_expect(1, 12, rl, 30, miss);
    run_capture(30, drop);
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (cap[k] !== expv[k]) begin
        errors++; $display("FAIL areset_restart cyc=%0d got=%h exp=%h", k, cap[k], expv[k]);
      end
    end
  endtask

`ifdef PATTERN_GEN_EN
  task automatic test_pattern;
    logic [15:0] bars [8];
    int rdc;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    load_fifo(4);
    pat_sel_c = 1'b1;
    en_c = 1'b1;
    rdc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) en_c = 1'b0;
      rdc += int'(rd_c);
      if (if_c.post_clken) begin
        checks++;
        if (if_c.post_imgdata !== bars[if_c.px / 2]) begin
          errors++; $display("FAIL pattern px=%0d got=%h exp=%h", if_c.px, if_c.post_imgdata, bars[if_c.px / 2]);
        end
      end
    end
    checks++;
    if (rdc !== 0) begin errors++; $display("FAIL pattern_rd_en got=%0d exp=0", rdc); end
    checks++;
    if (uf_c !== 16'h0) begin errors++; $display("FAIL pattern_underflow got=%0d exp=0", uf_c); end
    pat_sel_c = 1'b0;
    load_fifo(0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fifo_frame();
    test_underflow();
    test_clk_div();
    test_en_drop();
    test_async_reset();
`ifdef PATTERN_GEN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
